// File: rtl/calc_entry.sv
// rtl/calc_entry.sv - keypad entry FSM collecting two 4-bit operands for a downstream adder
module calc_entry (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       KEY_VALID,
    input  logic [3:0] KEY_DIGIT,
    input  logic       KEY_ADD,
    input  logic       KEY_EQ,
    input  logic       KEY_CLR,
    output logic [3:0] A_DATA,
    output logic [3:0] B_DATA,
    output logic       CALC_VALID,
    output logic       ERR,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        ENTER_A = 2'b00,
        ENTER_B = 2'b01,
        RESULT  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [1:0] cnt_q, cnt_d;
    logic       calc_valid_q, calc_valid_d;
    logic       err_q, err_d;

    logic [3:0] oper;
    logic [7:0] oper_x10;
    logic       digit_bad;
    logic [3:0] oper_new;
    logic [1:0] cnt_new;
    logic       entry_err;

    // Digit accumulation on the operand currently being entered; the
    // shifted value keeps all 8 bits so 9*10+9 cannot alias below 16.
    always_comb begin
        oper      = (state_q == ENTER_B) ? b_q : a_q;
        oper_x10  = {4'd0, oper} * 8'd10 + {4'd0, KEY_DIGIT};
        digit_bad = (KEY_DIGIT > 4'd9);
        oper_new  = oper;
        cnt_new   = cnt_q;
        entry_err = 1'b0;
        if (digit_bad) begin
            entry_err = 1'b1;
        end else if (cnt_q == 2'd0) begin
            oper_new = KEY_DIGIT;
            cnt_new  = 2'd1;
        end else if (cnt_q == 2'd1 && oper_x10 <= 8'd15) begin
            oper_new = oper_x10[3:0];
            cnt_new  = 2'd2;
        end else begin
            entry_err = 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        calc_valid_d = 1'b0;
        err_d        = err_q;
        if (KEY_VALID) begin
            if (KEY_CLR) begin
                state_d = ENTER_A;
                a_d     = 4'd0;
                b_d     = 4'd0;
                cnt_d   = 2'd0;
                err_d   = 1'b0;
            end else if (KEY_EQ) begin
                if (state_q == ENTER_B) begin
                    if (cnt_q != 2'd0) begin
                        state_d      = RESULT;
                        calc_valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end else if (KEY_ADD) begin
                if (state_q == ENTER_A) begin
                    state_d = ENTER_B;
                    b_d     = 4'd0;
                    cnt_d   = 2'd0;
                end
            end else begin
                case (state_q)
                    ENTER_A: begin
                        a_d   = oper_new;
                        cnt_d = cnt_new;
                        err_d = err_q | entry_err;
                    end
                    ENTER_B: begin
                        b_d   = oper_new;
                        cnt_d = cnt_new;
                        err_d = err_q | entry_err;
                    end
                    default: begin
                        // A fresh digit after a result starts a new calculation.
                        if (digit_bad) begin
                            err_d = 1'b1;
                        end else begin
                            state_d = ENTER_A;
                            a_d     = KEY_DIGIT;
                            b_d     = 4'd0;
                            cnt_d   = 2'd1;
                            err_d   = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q      <= ENTER_A;
            a_q          <= 4'd0;
            b_q          <= 4'd0;
            cnt_q        <= 2'd0;
            calc_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            calc_valid_q <= calc_valid_d;
            err_q        <= err_d;
        end
    end

    assign A_DATA     = a_q;
    assign B_DATA     = b_q;
    assign CALC_VALID = calc_valid_q;
    assign ERR        = err_q;
    assign STATE      = state_q;

endmodule

// File: tb/tb_calc_entry.sv
// tb/tb_calc_entry.sv - table-driven scoreboard bench for calc_entry
module tb_calc_entry;

    logic       CLK;
    logic       RST_N;
    logic       KEY_VALID;
    logic [3:0] KEY_DIGIT;
    logic       KEY_ADD;
    logic       KEY_EQ;
    logic       KEY_CLR;
    logic [3:0] A_DATA;
    logic [3:0] B_DATA;
    logic       CALC_VALID;
    logic       ERR;
    logic [1:0] STATE;

    calc_entry dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .KEY_VALID  (KEY_VALID),
        .KEY_DIGIT  (KEY_DIGIT),
        .KEY_ADD    (KEY_ADD),
        .KEY_EQ     (KEY_EQ),
        .KEY_CLR    (KEY_CLR),
        .A_DATA     (A_DATA),
        .B_DATA     (B_DATA),
        .CALC_VALID (CALC_VALID),
        .ERR        (ERR),
        .STATE      (STATE)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       rst_n;
        logic       valid;
        logic [3:0] digit;
        logic       add;
        logic       eq;
        logic       clr;
        logic [1:0] e_state;
        logic [3:0] e_a;
        logic [3:0] e_b;
        logic       e_cv;
        logic       e_err;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] e_state;
        logic [3:0] e_a;
        logic [3:0] e_b;
        logic       e_cv;
        logic       e_err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   vectors_applied;
    int   miscompares;

    function automatic vec_t mk(input logic r, input logic v, input logic [3:0] d,
                                input logic ad, input logic e, input logic c,
                                input logic [1:0] es, input logic [3:0] ea,
                                input logic [3:0] eb, input logic ecv, input logic eerr);
        vec_t t;
        t.rst_n = r; t.valid = v; t.digit = d; t.add = ad; t.eq = e; t.clr = c;
        t.e_state = es; t.e_a = ea; t.e_b = eb; t.e_cv = ecv; t.e_err = eerr;
        return t;
    endfunction

    task automatic drive(input vec_t t, input int idx);
        exp_t x;
        RST_N     = t.rst_n;
        KEY_VALID = t.valid;
        KEY_DIGIT = t.digit;
        KEY_ADD   = t.add;
        KEY_EQ    = t.eq;
        KEY_CLR   = t.clr;
        x.idx = idx; x.e_state = t.e_state; x.e_a = t.e_a; x.e_b = t.e_b;
        x.e_cv = t.e_cv; x.e_err = t.e_err;
        sb.push_back(x);
    endtask

    task automatic check_head();
        exp_t x;
        x = sb.pop_front();
        vectors_applied++;
        if (STATE !== x.e_state) begin
            miscompares++;
            $display("FAIL v%0d state: got %0d want %0d", x.idx, STATE, x.e_state);
        end
        if (A_DATA !== x.e_a) begin
            miscompares++;
            $display("FAIL v%0d a_data: got %0d want %0d", x.idx, A_DATA, x.e_a);
        end
        if (B_DATA !== x.e_b) begin
            miscompares++;
            $display("FAIL v%0d b_data: got %0d want %0d", x.idx, B_DATA, x.e_b);
        end
        if (CALC_VALID !== x.e_cv) begin
            miscompares++;
            $display("FAIL v%0d calc_valid: got %0b want %0b", x.idx, CALC_VALID, x.e_cv);
        end
        if (ERR !== x.e_err) begin
            miscompares++;
            $display("FAIL v%0d err: got %0b want %0b", x.idx, ERR, x.e_err);
        end
    endtask

    task automatic step(input vec_t t, input int idx);
        drive(t, idx);
        @(posedge CLK);
        #1;
        check_head();
    endtask

    initial begin
        int pulses;
        int cycles;
        vectors_applied = 0;
        miscompares     = 0;
        RST_N = 1'b0; KEY_VALID = 1'b0; KEY_DIGIT = 4'd0;
        KEY_ADD = 1'b0; KEY_EQ = 1'b0; KEY_CLR = 1'b0;

        //             rst v  dig   add eq clr  state a     b     cv err
        vecs.push_back(mk(0, 0, 4'd0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd7, 0, 0, 0, 2'd0, 4'd7, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 1, 0, 0, 2'd1, 4'd7, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd8, 0, 0, 0, 2'd1, 4'd7, 4'd8, 0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0, 1, 0, 2'd2, 4'd7, 4'd8, 1, 0));
        vecs.push_back(mk(1, 0, 4'd0, 0, 0, 0, 2'd2, 4'd7, 4'd8, 0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0, 1, 0, 2'd2, 4'd7, 4'd8, 0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 1, 0, 0, 2'd2, 4'd7, 4'd8, 0, 0));
        vecs.push_back(mk(1, 1, 4'd3, 0, 0, 0, 2'd0, 4'd3, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0, 0, 1, 2'd0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd1, 0, 0, 0, 2'd0, 4'd1, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd5, 0, 0, 0, 2'd0, 4'd15, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd3, 0, 0, 0, 2'd0, 4'd15, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 4'd0, 1, 0, 0, 2'd1, 4'd15, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 4'd1, 0, 0, 0, 2'd1, 4'd15, 4'd1, 0, 1));
        vecs.push_back(mk(1, 1, 4'd6, 0, 0, 0, 2'd1, 4'd15, 4'd1, 0, 1));
        vecs.push_back(mk(1, 1, 4'd4, 0, 1, 1, 2'd0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 1, 0, 0, 2'd1, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd0, 0, 1, 0, 2'd1, 4'd0, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 4'd2, 0, 0, 0, 2'd1, 4'd0, 4'd2, 0, 1));
        vecs.push_back(mk(0, 1, 4'd0, 0, 1, 0, 2'd0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 0, 4'd0, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd10, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 1));
        vecs.push_back(mk(1, 0, 4'd5, 0, 0, 0, 2'd0, 4'd0, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 4'd0, 0, 0, 1, 2'd0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd9, 0, 0, 0, 2'd0, 4'd9, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd9, 0, 0, 0, 2'd0, 4'd9, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 4'd0, 0, 0, 1, 2'd0, 4'd0, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd1, 0, 0, 0, 2'd0, 4'd1, 4'd0, 0, 0));
        vecs.push_back(mk(1, 1, 4'd6, 0, 0, 0, 2'd0, 4'd1, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 4'd0, 0, 1, 0, 2'd0, 4'd1, 4'd0, 0, 1));
        vecs.push_back(mk(1, 1, 4'd0, 0, 0, 1, 2'd0, 4'd0, 4'd0, 0, 0));

        @(negedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i], i);
        end

        // 1 + 2 =, then count CALC_VALID pulses over a bounded idle window.
        step(mk(1, 1, 4'd1, 0, 0, 0, 2'd0, 4'd1, 4'd0, 0, 0), 100);
        step(mk(1, 1, 4'd0, 1, 0, 0, 2'd1, 4'd1, 4'd0, 0, 0), 101);
        step(mk(1, 1, 4'd2, 0, 0, 0, 2'd1, 4'd1, 4'd2, 0, 0), 102);
        RST_N = 1'b1; KEY_VALID = 1'b1; KEY_DIGIT = 4'd0;
        KEY_ADD = 1'b0; KEY_EQ = 1'b1; KEY_CLR = 1'b0;
        pulses = 0;
        cycles = 0;
        while (cycles < 8) begin
            @(posedge CLK);
            #1;
            KEY_VALID = 1'b0;
            KEY_EQ    = 1'b0;
            if (CALC_VALID === 1'b1) pulses++;
            cycles++;
        end
        vectors_applied++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL pulse_count: got %0d want 1", pulses);
        end
        step(mk(1, 1, 4'd0, 0, 1, 0, 2'd2, 4'd1, 4'd2, 0, 0), 103);
        step(mk(1, 1, 4'd11, 0, 0, 0, 2'd2, 4'd1, 4'd2, 0, 1), 104);
        step(mk(1, 0, 4'd0, 0, 0, 0, 2'd2, 4'd1, 4'd2, 0, 1), 105);

        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
